// File: rtl/alarm_scheduler_pkg.sv
// Shared types for the alarm scheduler: ringer state encoding, default time width, counter sizing.
// No logic; no latency; no backpressure.
// Imported by alarm_scheduler and alarm_tick_timer.
package alarm_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RING = 2'd1,
        ST_SNZ  = 2'd2
    } state_e;

    localparam int DEF_TIME_W = 13;

    // Bits needed to hold values up to max(a,b)-1, never less than one.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/alarm_tick_timer.sv
// Saturating SEC_TICK counter; done pulses on the tick that finds the count at limit.
// Latency: done is combinational from the current count and tick; count updates next edge.
// Backpressure: none; clear has priority over tick.
module alarm_tick_timer #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != limit) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign done = tick & (cnt_q == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Per-day alarm slots, registered time compare and ringer FSM; ALARM_SNOOZE_LIMIT_EN caps snoozes.
// Latency: MATCH one edge after CT/CD match, AA one edge after MATCH rises.
// Backpressure: none; STOP > SNOOZE > fire > tick when they coincide.
module alarm_scheduler
    import alarm_scheduler_pkg::*;
#(
    parameter int TIME_W     = DEF_TIME_W,
    parameter int NUM_DAYS   = 7,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3,
    parameter int DAY_W      = (NUM_DAYS > 1) ? $clog2(NUM_DAYS) : 1
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic [TIME_W-1:0] CT,
    input  logic [DAY_W-1:0]  CD,
    input  logic              SEC_TICK,
    input  logic              WE,
    input  logic [DAY_W-1:0]  WADDR,
    input  logic [TIME_W-1:0] WDATA,
    input  logic              WEN,
    input  logic              SNOOZE,
    input  logic              STOP,
    output logic              AA,
    output logic              SNZ,
    output logic              MATCH
);

    localparam int CNT_W = cnt_width(RING_SEC, SNOOZE_SEC);
    localparam logic [CNT_W-1:0] RING_LIM = CNT_W'(RING_SEC - 1);
    localparam logic [CNT_W-1:0] SNZ_LIM  = CNT_W'(SNOOZE_SEC - 1);

    logic [TIME_W-1:0]   slot_q [NUM_DAYS];
    logic [TIME_W-1:0]   slot_d [NUM_DAYS];
    logic [NUM_DAYS-1:0] en_q, en_d;
    logic                match_q, match_d;
    logic                fire_q, fire_d;
    state_e              state_q, state_d;
    logic                aa_q, aa_d;
    logic                snz_q, snz_d;
    logic                tmr_clear, tmr_done;
    logic [CNT_W-1:0]    tmr_limit;

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int SC_W = cnt_width(MAX_SNOOZE + 1, 1);
    logic [SC_W-1:0] snz_cnt_q, snz_cnt_d;
`endif

    // Out-of-range WADDR/CD simply match no slot, so those writes drop and never compare.
    always_comb begin
        slot_d  = slot_q;
        en_d    = en_q;
        match_d = 1'b0;
        for (int i = 0; i < NUM_DAYS; i++) begin
            if (WE && (WADDR == DAY_W'(i))) begin
                slot_d[i] = WDATA;
                en_d[i]   = WEN;
            end
            if ((CD == DAY_W'(i)) && en_q[i] && (slot_q[i] == CT)) begin
                match_d = 1'b1;
            end
        end
        fire_d = match_d & ~match_q;
    end

    always_comb begin
        state_d = state_q;
`ifdef ALARM_SNOOZE_LIMIT_EN
        snz_cnt_d = snz_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fire_q) begin
                    state_d = ST_RING;
`ifdef ALARM_SNOOZE_LIMIT_EN
                    snz_cnt_d = '0;
`endif
                end
            end
            ST_RING: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (SNOOZE) begin
`ifdef ALARM_SNOOZE_LIMIT_EN
                    if (snz_cnt_q == SC_W'(MAX_SNOOZE)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_SNZ;
                        snz_cnt_d = snz_cnt_q + 1'b1;
                    end
`else
                    state_d = ST_SNZ;
`endif
                end else if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SNZ: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (fire_q || tmr_done) begin
                    state_d = ST_RING;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        aa_d  = (state_d == ST_RING);
        snz_d = (state_d == ST_SNZ);
    end

    // Every state change restarts the second counter from zero.
    assign tmr_clear = (state_d != state_q) || (state_q == ST_IDLE);
    assign tmr_limit = (state_q == ST_SNZ) ? SNZ_LIM : RING_LIM;

    alarm_tick_timer #(
        .CNT_W (CNT_W)
    ) u_tick_timer (
        .clk   (CLK),
        .rst_n (CLR_N),
        .clear (tmr_clear),
        .tick  (SEC_TICK),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            for (int i = 0; i < NUM_DAYS; i++) begin
                slot_q[i] <= '0;
            end
            en_q    <= '0;
            match_q <= 1'b0;
            fire_q  <= 1'b0;
            state_q <= ST_IDLE;
            aa_q    <= 1'b0;
            snz_q   <= 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snz_cnt_q <= '0;
`endif
        end else begin
            slot_q  <= slot_d;
            en_q    <= en_d;
            match_q <= match_d;
            fire_q  <= fire_d;
            state_q <= state_d;
            aa_q    <= aa_d;
            snz_q   <= snz_d;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snz_cnt_q <= snz_cnt_d;
`endif
        end
    end

    assign AA    = aa_q;
    assign SNZ   = snz_q;
    assign MATCH = match_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed and randomized bench for alarm_scheduler with RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2.
// A countdown-based reference model predicts AA/SNZ/MATCH after every edge.
module tb_alarm_scheduler;

    localparam int RING  = 4;
    localparam int SNZS  = 3;
    localparam int MAXS  = 2;
`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr_n;
    logic [12:0] ct;
    logic [2:0]  cd;
    logic        sec_tick, we, wen, snooze, stop;
    logic [2:0]  waddr;
    logic [12:0] wdata;
    logic        aa, snz, match;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 ringing, 2 snoozed; left = ticks remaining.
    int          m_mode, m_left, m_snzs;
    bit          m_match, m_firep;
    logic [12:0] m_slot [8];
    bit          m_en   [8];

    alarm_scheduler #(
        .TIME_W     (13),
        .NUM_DAYS   (7),
        .RING_SEC   (RING),
        .SNOOZE_SEC (SNZS),
        .MAX_SNOOZE (MAXS)
    ) dut (
        .CLK      (clk),
        .CLR_N    (clr_n),
        .CT       (ct),
        .CD       (cd),
        .SEC_TICK (sec_tick),
        .WE       (we),
        .WADDR    (waddr),
        .WDATA    (wdata),
        .WEN      (wen),
        .SNOOZE   (snooze),
        .STOP     (stop),
        .AA       (aa),
        .SNZ      (snz),
        .MATCH    (match)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_left = 0; m_snzs = 0; m_match = 0; m_firep = 0;
        for (int i = 0; i < 8; i++) begin
            m_slot[i] = '0;
            m_en[i]   = 0;
        end
    endfunction

    function automatic void model_step();
        bit mm;
        mm = (cd < 3'd7) && m_en[cd] && (m_slot[cd] == ct);
        case (m_mode)
            0: if (m_firep) begin m_mode = 1; m_left = RING; m_snzs = 0; end
            1: begin
                if (stop) m_mode = 0;
                else if (snooze) begin
                    if (LIMIT_ON && m_snzs == MAXS) m_mode = 0;
                    else begin m_snzs++; m_mode = 2; m_left = SNZS; end
                end else if (sec_tick) begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end
            default: begin
                if (stop) m_mode = 0;
                else if (m_firep) begin m_mode = 1; m_left = RING; end
                else if (sec_tick) begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 1; m_left = RING; end
                end
            end
        endcase
        if (we && waddr < 3'd7) begin
            m_slot[waddr] = wdata;
            m_en[waddr]   = wen;
        end
        m_firep = mm && !m_match;
        m_match = mm;
    endfunction

    task automatic cyc(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, "_aa"},    aa,    (m_mode == 1));
        chk({tag, "_snz"},   snz,   (m_mode == 2));
        chk({tag, "_match"}, match, m_match);
        @(negedge clk);
        we = 0; snooze = 0; stop = 0; sec_tick = 0;
    endtask

    task automatic retrigger(input string tag);
        ct = 13'h000;
        cyc(tag);
        ct = 13'h0A5;
        cyc(tag);
        cyc(tag);
    endtask

    initial begin
        logic [12:0] vals [4];
        vals[0] = 13'h0A5; vals[1] = 13'h123; vals[2] = 13'h055; vals[3] = 13'h1FF;

        clr_n = 0; ct = '0; cd = '0; sec_tick = 0; we = 0; waddr = '0;
        wdata = '0; wen = 0; snooze = 0; stop = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_aa", aa, 0);
        chk("rst_snz", snz, 0);
        chk("rst_match", match, 0);
        clr_n = 1;

        // 1: write slot1, match, fire exactly once
        we = 1; waddr = 3'd1; wdata = 13'h0A5; wen = 1;
        cyc("t1_wr");
        cd = 3'd1; ct = 13'h0A5;
        cyc("t1_m");
        chk("t1_match1", match, 1);
        chk("t1_aa_early", aa, 0);
        cyc("t1_a");
        chk("t1_aa1", aa, 1);
        repeat (3) cyc("t1_hold");

        // 2: auto-timeout after RING ticks
        for (int k = 0; k < RING; k++) begin
            sec_tick = 1;
            cyc("t2_tick");
            if (k == RING - 2) chk("t2_aa_before", aa, 1);
        end
        chk("t2_aa_off", aa, 0);
        repeat (2) cyc("t2_hold");

        // 3: snooze then resume after SNZS ticks
        retrigger("t3_trig");
        chk("t3_ring", aa, 1);
        snooze = 1;
        cyc("t3_snz");
        chk("t3_aa0", aa, 0);
        chk("t3_snz1", snz, 1);
        for (int k = 0; k < SNZS; k++) begin
            sec_tick = 1;
            cyc("t3_tick");
        end
        chk("t3_aa_back", aa, 1);
        chk("t3_snz_off", snz, 0);

        // 4: STOP beats SNOOZE
        snooze = 1; stop = 1;
        cyc("t4_both");
        chk("t4_aa", aa, 0);
        chk("t4_snz", snz, 0);

        // 6a: snooze limit
        retrigger("t6_trig");
        for (int r = 0; r < 2; r++) begin
            snooze = 1;
            cyc("t6_snz");
            for (int k = 0; k < SNZS; k++) begin
                sec_tick = 1;
                cyc("t6_tick");
            end
        end
        snooze = 1;
        cyc("t6_third");
        chk("t6_third_snz", snz, LIMIT_ON ? 0 : 1);
        chk("t6_third_aa", aa, 0);
        stop = 1;
        cyc("t6_stop");

        // 5: disabled slot, out-of-range day and dropped write
        we = 1; waddr = 3'd2; wdata = 13'h123; wen = 0;
        cyc("t5_wr");
        we = 1; waddr = 3'd7; wdata = 13'h0A5; wen = 1;
        cyc("t5_wr7");
        cd = 3'd2; ct = 13'h123;
        repeat (2) cyc("t5_dis");
        chk("t5_dis_match", match, 0);
        chk("t5_dis_aa", aa, 0);
        cd = 3'd7; ct = 13'h0A5;
        repeat (2) cyc("t5_cd7");
        chk("t5_cd7_match", match, 0);
        chk("t5_cd7_aa", aa, 0);

        // 6b: asynchronous reset mid-ring
        cd = 3'd1;
        retrigger("t6r_trig");
        chk("t6r_ring", aa, 1);
        #2 clr_n = 0;
        #1;
        chk("t6r_aa", aa, 0);
        chk("t6r_match", match, 0);
        model_reset();
        @(negedge clk);
        clr_n = 1;

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            ct       = vals[$urandom_range(0, 3)];
            cd       = 3'($urandom_range(0, 7));
            sec_tick = ($urandom_range(0, 2) == 0);
            snooze   = ($urandom_range(0, 15) == 0);
            stop     = ($urandom_range(0, 31) == 0);
            we       = ($urandom_range(0, 7) == 0);
            waddr    = 3'($urandom_range(0, 7));
            wdata    = vals[$urandom_range(0, 3)];
            wen      = ($urandom_range(0, 3) != 0);
            cyc("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
